// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 4-stage pipeline: stall/flush/freeze
// generation, EX operand forwarding selects, memory-wait supervision and stall counting.
module pipeline_hazard_ctrl #(
    parameter int REGW        = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [REGW-1:0] id_src1,
    input  logic [REGW-1:0] id_src2,
    input  logic [REGW-1:0] id_src3,
    input  logic            id_use1,
    input  logic            id_use2,
    input  logic            id_use3,
    input  logic [REGW-1:0] ex_src1,
    input  logic [REGW-1:0] ex_src2,
    input  logic [REGW-1:0] ex_src3,
    input  logic [REGW-1:0] ex_destReg,
    input  logic            ex_wreg,
    input  logic            ex_rmem,
    input  logic            ex_jmp,
    input  logic            ex_wpc,
    input  logic [REGW-1:0] mem_destReg,
    input  logic            mem_wreg,
    input  logic            mem_rmem,
    input  logic            mem_wmem,
    input  logic [REGW-1:0] wb_destReg,
    input  logic            wb_wreg,
    input  logic            mem_ack,
    output logic            stall_if,
    output logic            stall_id,
    output logic            flush_if,
    output logic            flush_id,
    output logic            freeze,
    output logic [1:0]      fwd1,
    output logic [1:0]      fwd2,
    output logic [1:0]      fwd3,
    output logic            mem_err,
    output logic [15:0]     stall_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        ERROR   = 2'd2
    } state_t;

    localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_err_q, mem_err_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        mreq;
    logic        redirect;
    logic        load_use;
    logic [8:0]  wait_next;
    logic        freeze_c;
    logic        stall_c;
    logic        flush_if_c;
    logic        flush_id_c;

    // Newest producer first; a load sitting in MEM has no data yet and never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [REGW-1:0] src,
        input logic [REGW-1:0] m_dest,
        input logic            m_wreg,
        input logic            m_rmem,
        input logic [REGW-1:0] w_dest,
        input logic            w_wreg
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (m_wreg && !m_rmem && (m_dest == src)) begin
            sel = 2'b01;
        end else if (w_wreg && (w_dest == src)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    assign mreq     = mem_rmem | mem_wmem;
    assign redirect = ex_jmp | ex_wpc;
    assign load_use = ex_rmem & ex_wreg &
                      ((id_use1 & (id_src1 == ex_destReg)) |
                       (id_use2 & (id_src2 == ex_destReg)) |
                       (id_use3 & (id_src3 == ex_destReg)));

    always_comb begin
        fwd1 = fwd_sel(ex_src1, mem_destReg, mem_wreg, mem_rmem, wb_destReg, wb_wreg);
        fwd2 = fwd_sel(ex_src2, mem_destReg, mem_wreg, mem_rmem, wb_destReg, wb_wreg);
        fwd3 = fwd_sel(ex_src3, mem_destReg, mem_wreg, mem_rmem, wb_destReg, wb_wreg);
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        stall_cnt_d = stall_cnt_q;
        freeze_c    = 1'b0;
        stall_c     = 1'b0;
        flush_if_c  = 1'b0;
        flush_id_c  = 1'b0;
        wait_next   = {1'b0, wait_cnt_q} + 9'd1;

        case (state_q)
            RUN: begin
                if (mreq && !mem_ack) begin
                    freeze_c   = 1'b1;
                    state_d    = MEMWAIT;
                    wait_cnt_d = '0;
                end
            end
            MEMWAIT: begin
                wait_cnt_d = wait_next[8] ? wait_cnt_q : wait_next[7:0];
                if (mem_ack) begin
                    state_d = RUN;
                end else begin
                    freeze_c = 1'b1;
                    // The presenting RUN cycle already froze once, so the limit
                    // is checked against the count including this cycle.
                    if (wait_next >= TIMEOUT_LIM) begin
                        state_d   = ERROR;
                        mem_err_d = 1'b1;
                    end
                end
            end
            ERROR: begin
                freeze_c = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (!freeze_c) begin
            if (redirect) begin
                flush_if_c = 1'b1;
                flush_id_c = 1'b1;
            end else if (load_use) begin
                stall_c    = 1'b1;
                flush_id_c = 1'b1;
            end
        end

        if ((stall_c || freeze_c) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Control outputs are forced low for the whole time reset is held.
    assign freeze    = freeze_c & rst;
    assign stall_if  = stall_c & rst;
    assign stall_id  = stall_c & rst;
    assign flush_if  = flush_if_c & rst;
    assign flush_id  = flush_id_c & rst;
    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized scoreboard bench for pipeline_hazard_ctrl with a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int REGW    = 4;
    localparam int TIMEOUT = 3;

    typedef struct packed {
        logic            rst;
        logic [2:0][3:0] id_src;
        logic [2:0]      id_use;
        logic [2:0][3:0] ex_src;
        logic [3:0]      ex_dest;
        logic            ex_wreg;
        logic            ex_rmem;
        logic            ex_jmp;
        logic            ex_wpc;
        logic [3:0]      mem_dest;
        logic            mem_wreg;
        logic            mem_rmem;
        logic            mem_wmem;
        logic [3:0]      wb_dest;
        logic            wb_wreg;
        logic            mem_ack;
    } stim_t;

    typedef struct packed {
        logic [4:0]      ctrl;
        logic [2:0][1:0] fwd;
        logic            mem_err;
        logic [15:0]     stall_cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [REGW-1:0] id_src1, id_src2, id_src3, ex_src1, ex_src2, ex_src3;
    logic [REGW-1:0] ex_destReg, mem_destReg, wb_destReg;
    logic id_use1, id_use2, id_use3;
    logic ex_wreg, ex_rmem, ex_jmp, ex_wpc;
    logic mem_wreg, mem_rmem, mem_wmem, wb_wreg, mem_ack;
    logic stall_if, stall_id, flush_if, flush_id, freeze, mem_err;
    logic [1:0] fwd1, fwd2, fwd3;
    logic [15:0] stall_cnt;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;

    int   m_err = 0;
    int   m_wait = 0;
    int   m_fc = 0;
    int   m_cnt = 0;

    pipeline_hazard_ctrl #(.REGW(REGW), .MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_src3(id_src3),
        .id_use1(id_use1), .id_use2(id_use2), .id_use3(id_use3),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_src3(ex_src3),
        .ex_destReg(ex_destReg), .ex_wreg(ex_wreg), .ex_rmem(ex_rmem),
        .ex_jmp(ex_jmp), .ex_wpc(ex_wpc),
        .mem_destReg(mem_destReg), .mem_wreg(mem_wreg), .mem_rmem(mem_rmem), .mem_wmem(mem_wmem),
        .wb_destReg(wb_destReg), .wb_wreg(wb_wreg), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_id(stall_id), .flush_if(flush_if), .flush_id(flush_id),
        .freeze(freeze), .fwd1(fwd1), .fwd2(fwd2), .fwd3(fwd3),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] ref_fwd(input logic [3:0] src, input stim_t s);
        if (s.mem_wreg && !s.mem_rmem && s.mem_dest == src) return 2'b01;
        if (s.wb_wreg && s.wb_dest == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = idle_stim();
        for (int k = 0; k < 3; k++) begin
            s.id_src[k] = 4'($urandom_range(0, 3));
            s.ex_src[k] = 4'($urandom_range(0, 3));
            s.id_use[k] = 1'($urandom);
        end
        s.ex_dest  = 4'($urandom_range(0, 3));
        s.mem_dest = 4'($urandom_range(0, 3));
        s.wb_dest  = 4'($urandom_range(0, 3));
        s.ex_wreg  = 1'($urandom);
        s.ex_rmem  = 1'($urandom);
        s.ex_jmp   = ($urandom_range(0, 7) == 0);
        s.ex_wpc   = ($urandom_range(0, 7) == 0);
        s.mem_wreg = 1'($urandom);
        s.mem_rmem = ($urandom_range(0, 5) == 0);
        s.mem_wmem = ($urandom_range(0, 7) == 0);
        s.wb_wreg  = 1'($urandom);
        s.mem_ack  = 1'($urandom);
        s.rst      = (m_err != 0 && $urandom_range(0, 3) == 0) ? 1'b0 :
                     ($urandom_range(0, 99) != 0);
        return s;
    endfunction

    // Drives one cycle of inputs, predicts the response and advances the model.
    task automatic apply_stimulus(input stim_t s);
        exp_t e;
        logic mreq, lu, redir, frz, stl, fif, fid;
        @(negedge clk);
        cycle++;
        rst = s.rst;
        id_src1 = s.id_src[0]; id_src2 = s.id_src[1]; id_src3 = s.id_src[2];
        id_use1 = s.id_use[0]; id_use2 = s.id_use[1]; id_use3 = s.id_use[2];
        ex_src1 = s.ex_src[0]; ex_src2 = s.ex_src[1]; ex_src3 = s.ex_src[2];
        ex_destReg = s.ex_dest; ex_wreg = s.ex_wreg; ex_rmem = s.ex_rmem;
        ex_jmp = s.ex_jmp; ex_wpc = s.ex_wpc;
        mem_destReg = s.mem_dest; mem_wreg = s.mem_wreg; mem_rmem = s.mem_rmem; mem_wmem = s.mem_wmem;
        wb_destReg = s.wb_dest; wb_wreg = s.wb_wreg; mem_ack = s.mem_ack;

        for (int k = 0; k < 3; k++) e.fwd[k] = ref_fwd(s.ex_src[k], s);
        if (!s.rst) begin
            m_err = 0; m_wait = 0; m_fc = 0; m_cnt = 0;
            e.ctrl = '0; e.mem_err = 1'b0; e.stall_cnt = '0;
        end else begin
            e.mem_err   = (m_err != 0);
            e.stall_cnt = 16'(m_cnt);
            mreq = s.mem_rmem | s.mem_wmem;
            if (m_err != 0)       frz = 1'b1;
            else if (m_wait != 0) frz = !s.mem_ack;
            else                  frz = mreq & !s.mem_ack;
            lu = 1'b0;
            for (int k = 0; k < 3; k++)
                if (s.id_use[k] && s.id_src[k] == s.ex_dest) lu = 1'b1;
            lu    = lu & s.ex_rmem & s.ex_wreg;
            redir = s.ex_jmp | s.ex_wpc;
            fif   = !frz && redir;
            fid   = !frz && (redir || lu);
            stl   = !frz && !redir && lu;
            e.ctrl = {stl, stl, fif, fid, frz};
            if ((stl || frz) && m_cnt < 65535) m_cnt++;
            if (m_err == 0) begin
                if (frz) begin
                    if (m_wait == 0) begin
                        m_wait = 1;
                        m_fc = 0;
                    end
                    m_fc++;
                    if (m_fc == TIMEOUT + 1) begin
                        m_err = 1;
                        m_wait = 0;
                    end
                end else begin
                    m_wait = 0;
                end
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic check_output(input exp_t e);
        tests++;
        if ({stall_if, stall_id, flush_if, flush_id, freeze} !== e.ctrl) begin
            fails++;
            $display("[TB] FAIL ctrl{sif,sid,fif,fid,frz} cycle %0d: got %b expected %b", cycle,
                     {stall_if, stall_id, flush_if, flush_id, freeze}, e.ctrl);
        end
        tests++;
        if ({fwd3, fwd2, fwd1} !== e.fwd) begin
            fails++;
            $display("[TB] FAIL fwd{3,2,1} cycle %0d: got %b expected %b", cycle, {fwd3, fwd2, fwd1}, e.fwd);
        end
        tests++;
        if (mem_err !== e.mem_err) begin
            fails++;
            $display("[TB] FAIL mem_err cycle %0d: got %b expected %b", cycle, mem_err, e.mem_err);
        end
        tests++;
        if (stall_cnt !== e.stall_cnt) begin
            fails++;
            $display("[TB] FAIL stall_cnt cycle %0d: got %0d expected %0d", cycle, stall_cnt, e.stall_cnt);
        end
    endtask

    // Monitor: pops predictions mid-cycle, well clear of the rising edge.
    always begin
        @(negedge clk);
        #2;
        while (exp_q.size() > 0) check_output(exp_q.pop_front());
    end

    initial begin
        stim_t s;
        s = idle_stim();
        s.rst = 1'b0;
        rst = 1'b0;
        {id_src1, id_src2, id_src3, ex_src1, ex_src2, ex_src3} = '0;
        {ex_destReg, mem_destReg, wb_destReg} = '0;
        {id_use1, id_use2, id_use3, ex_wreg, ex_rmem, ex_jmp, ex_wpc} = '0;
        {mem_wreg, mem_rmem, mem_wmem, wb_wreg, mem_ack} = '0;
        apply_stimulus(s);
        apply_stimulus(idle_stim());

        s = idle_stim();
        s.ex_rmem = 1'b1; s.ex_wreg = 1'b1; s.ex_dest = 4'd3;
        s.id_src[1] = 4'd3; s.id_use[1] = 1'b1;
        apply_stimulus(s);
        apply_stimulus(idle_stim());
        s.ex_jmp = 1'b1;
        apply_stimulus(s);
        apply_stimulus(idle_stim());

        s = idle_stim();
        s.ex_src[0] = 4'd5; s.mem_wreg = 1'b1; s.mem_dest = 4'd5;
        s.wb_wreg = 1'b1; s.wb_dest = 4'd5;
        apply_stimulus(s);
        s.mem_rmem = 1'b1; s.mem_ack = 1'b1;
        apply_stimulus(s);

        s = idle_stim();
        s.mem_rmem = 1'b1;
        repeat (4) apply_stimulus(s);
        s.mem_ack = 1'b1;
        apply_stimulus(s);
        apply_stimulus(idle_stim());

        s = idle_stim();
        s.mem_wmem = 1'b1;
        repeat (7) apply_stimulus(s);
        s.rst = 1'b0;
        apply_stimulus(s);
        apply_stimulus(idle_stim());

        s = idle_stim();
        s.mem_rmem = 1'b1;
        repeat (2) apply_stimulus(s);
        s.rst = 1'b0;
        apply_stimulus(s);
        s = idle_stim();
        s.mem_ack = 1'b1;
        apply_stimulus(s);
        apply_stimulus(idle_stim());

        repeat (4000) apply_stimulus(rand_stim());

        @(negedge clk);
        #4;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 4-stage CPU pipeline (IF, ID, EX, MEM/WB). Watches decode, EX-register, MEM and WB stage fields and drives the hold and bubble enables of the pipeline registers: stall, flush and freeze. Also produces operand forwarding selects for the EX stage and counts stall cycles. Sits beside the EX pipeline register and the data-memory port; it holds no datapath values.

## Interface
Parameters:
- REGW, 4, register-index width
- MEM_TIMEOUT, 255, maximum data-memory wait cycles before error

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- id_src1, id_src2, id_src3  in  REGW  source registers of the instruction in ID
- id_use1, id_use2, id_use3  in  1  matching source is actually read
- ex_src1, ex_src2, ex_src3  in  REGW  source registers of the instruction in EX
- ex_destReg  in  REGW  EX-stage destination
- ex_wreg, ex_rmem, ex_jmp, ex_wpc  in  1  EX-stage control bits
- mem_destReg  in  REGW  MEM-stage destination
- mem_wreg, mem_rmem, mem_wmem  in  1  MEM-stage control bits
- wb_destReg  in  REGW  WB-stage destination
- wb_wreg  in  1  WB-stage register write
- mem_ack  in  1  data memory completes the current access this cycle
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- flush_if  out  1  load bubble into IF/ID
- flush_id  out  1  load bubble into ID/EX (all control bits 0)
- freeze  out  1  hold every pipeline register and PC
- fwd1, fwd2, fwd3  out  2  EX operand select: 00 regfile, 01 MEM result, 10 WB result
- mem_err  out  1  sticky memory-timeout flag
- stall_cnt  out  16  saturating stall-cycle counter

## Operation
- FSM states: RUN, MEMWAIT, ERROR. Reset state is RUN.
- mreq = mem_rmem | mem_wmem.
- RUN:
  - If mreq & !mem_ack: freeze=1, go to MEMWAIT, clear the wait counter.
  - Otherwise, if ex_jmp | ex_wpc (redirect): flush_if=1 and flush_id=1, stalls 0. Redirect overrides load-use.
  - Otherwise, on load-use: stall_if=1, stall_id=1, flush_id=1.
    - Load-use condition: ex_rmem & ex_wreg & (for any k: id_usek & id_srck==ex_destReg).
- MEMWAIT:
  - freeze = !mem_ack. The wait counter increments each cycle.
  - On mem_ack: freeze=0 in that same cycle and go to RUN. The redirect, load-use and forwarding logic is evaluated normally in that cycle.
  - If the counter reaches MEM_TIMEOUT with no ack: go to ERROR and set mem_err.
- ERROR: freeze=1 permanently. Only rst exits this state.
- While freeze=1, all other stall and flush outputs are 0. freeze dominates everything.
- Forwarding, per operand k:
  - 01 if mem_wreg & !mem_rmem & mem_destReg==ex_srck.
  - Else 10 if wb_wreg & wb_destReg==ex_srck.
  - Else 00.
  - The newest producer wins. A load in MEM never forwards; the load-use stall guarantees that case never reaches EX.
- stall_cnt increments on every cycle with stall_if | freeze asserted. It saturates at 0xFFFF.

## Timing
- All stall, flush, freeze and fwd outputs are combinational from the current state and inputs. Registered state: FSM state, wait counter (8 bits), mem_err, stall_cnt.
- Async reset: state=RUN, wait counter=0, mem_err=0, stall_cnt=0. As a consequence every output is 0 while rst=0, except fwd, which follows the inputs.
- The load-use stall lasts exactly 1 cycle with no FSM involvement: the next cycle the load is in MEM, and it forwards from WB one cycle after that.
- A memory access that acks in the same cycle it is presented causes 0 freeze cycles. A first ack after N waiting cycles causes exactly N freeze cycles.
- Timeout: ERROR is entered on the edge after the counter equals MEM_TIMEOUT, giving MEM_TIMEOUT+1 freeze cycles before mem_err=1.
- Reset mid-MEMWAIT returns the FSM to RUN immediately. A subsequent ack is ignored unless mreq is asserted.

## Test plan
- Load-use: ex_rmem=1, ex_wreg=1, ex_destReg=3, id_src2=3, id_use2=1 -> for exactly one cycle stall_if=stall_id=flush_id=1, flush_if=0, and stall_cnt increments by 1.
- Redirect beats load-use: load-use condition true and ex_jmp=1 in the same cycle -> flush_if=flush_id=1, stall_if=0.
- Forward priority: ex_src1=5; mem_wreg=1 with mem_destReg=5; wb_wreg=1 with wb_destReg=5 -> fwd1=01. Set mem_rmem=1 -> fwd1=10.
- Memory wait: mreq with mem_ack low for 4 cycles, then high -> freeze=1 for 4 cycles, 0 in the ack cycle, and stall_cnt=4.
- Timeout with MEM_TIMEOUT=3: mreq with mem_ack held low -> mem_err=1 after 4 freeze cycles and freeze stays 1. Asserting rst=0 clears everything.
- Reset during MEMWAIT: pulse rst=0 at freeze cycle 2 -> outputs go to 0 asynchronously, and the FSM is in RUN after release.
